// File: rtl/apb_top.sv
// APB3 master/slave pair: the master turns transfer requests into SETUP/ACCESS
// phases, and the slave is a 256x8 register file with zero wait states.

module apb_master (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_transfer,
    input  logic       i_write_en,
    input  logic [7:0] i_din,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_prdata,
    input  logic       i_pready,
    output logic       o_psel,
    output logic       o_penable,
    output logic       o_pwrite,
    output logic [7:0] o_paddr,
    output logic [7:0] o_pwdata,
    output logic [7:0] o_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_launch;
    logic       w_done;
    logic       r_pwrite;
    logic [7:0] r_paddr;
    logic [7:0] r_pwdata;
    logic [7:0] r_dout;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // w_launch marks the edges where a new request is captured: leaving IDLE,
    // or chaining straight from a completed ACCESS into the next SETUP.
    always_comb begin
        w_next    = r_state;
        o_psel    = 1'b0;
        o_penable = 1'b0;
        w_launch  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_transfer) begin
                    w_next   = SETUP;
                    w_launch = 1'b1;
                end
            end
            SETUP: begin
                o_psel = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                o_psel    = 1'b1;
                o_penable = 1'b1;
                if (i_pready) begin
                    w_done = 1'b1;
                    if (i_transfer) begin
                        w_next   = SETUP;
                        w_launch = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwrite <= 1'b0;
            r_paddr  <= 8'h00;
            r_pwdata <= 8'h00;
        end else if (w_launch) begin
            r_pwrite <= i_write_en;
            r_paddr  <= i_addr;
            r_pwdata <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                     r_dout <= 8'h00;
        else if (w_done && !r_pwrite)  r_dout <= i_prdata;
    end

    assign o_pwrite = r_pwrite;
    assign o_paddr  = r_paddr;
    assign o_pwdata = r_pwdata;
    assign o_dout   = r_dout;

endmodule

module apb_slave (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_psel,
    input  logic       i_penable,
    input  logic       i_pwrite,
    input  logic [7:0] i_paddr,
    input  logic [7:0] i_pwdata,
    output logic [7:0] o_prdata,
    output logic       o_pready
);

    logic [7:0] r_mem [256];
    logic       w_wr;

    assign o_pready = 1'b1;
    assign w_wr     = i_psel & i_penable & i_pwrite & o_pready;
    assign o_prdata = r_mem[i_paddr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) r_mem[i] <= 8'h00;
        end else if (w_wr) begin
            r_mem[i_paddr] <= i_pwdata;
        end
    end

endmodule

module apb_top (
    input  logic       clk,
    input  logic       reset,
    input  logic       transfer,
    input  logic       write_en,
    input  logic [7:0] din,
    input  logic [7:0] addr_in,
    output logic [7:0] dout
);

    logic       w_psel;
    logic       w_penable;
    logic       w_pwrite;
    logic [7:0] w_paddr;
    logic [7:0] w_pwdata;
    logic [7:0] w_prdata;
    logic       w_pready;

    apb_master u_master (
        .clk        (clk),
        .reset      (reset),
        .i_transfer (transfer),
        .i_write_en (write_en),
        .i_din      (din),
        .i_addr     (addr_in),
        .i_prdata   (w_prdata),
        .i_pready   (w_pready),
        .o_psel     (w_psel),
        .o_penable  (w_penable),
        .o_pwrite   (w_pwrite),
        .o_paddr    (w_paddr),
        .o_pwdata   (w_pwdata),
        .o_dout     (dout)
    );

    apb_slave u_slave (
        .clk       (clk),
        .reset     (reset),
        .i_psel    (w_psel),
        .i_penable (w_penable),
        .i_pwrite  (w_pwrite),
        .i_paddr   (w_paddr),
        .i_pwdata  (w_pwdata),
        .o_prdata  (w_prdata),
        .o_pready  (w_pready)
    );

endmodule

// File: tb/tb_apb_top.sv
// Bench for apb_top: directed scenarios plus random traffic, checked against a
// transaction-level model (request accepted at edge n commits at edge n+2).

module tb_apb_top;

    logic       clk = 1'b0;
    logic       reset, transfer, write_en;
    logic [7:0] din, addr_in, dout;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0] m_mem [256];
    logic [7:0] m_dout;
    bit         m_pend;
    int         m_pedge;
    bit         m_pwe;
    logic [7:0] m_pa, m_pd;
    int         m_free;
    int         edge_n = 0;

    apb_top dut (
        .clk      (clk),
        .reset    (reset),
        .transfer (transfer),
        .write_en (write_en),
        .din      (din),
        .addr_in  (addr_in),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Apply inputs, advance one edge, update the model, then compare dout.
    task automatic tick(input bit rst, input bit tr, input bit we,
                        input logic [7:0] a, input logic [7:0] d);
        reset = rst; transfer = tr; write_en = we; addr_in = a; din = d;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
            m_dout = 8'h00;
            m_pend = 1'b0;
            m_free = edge_n + 1;
        end else begin
            if (m_pend && m_pedge == edge_n) begin
                if (m_pwe) m_mem[m_pa] = m_pd;
                else       m_dout = m_mem[m_pa];
                m_pend = 1'b0;
            end
            if (edge_n >= m_free && tr) begin
                m_pend  = 1'b1;
                m_pedge = edge_n + 2;
                m_free  = edge_n + 2;
                m_pwe   = we; m_pa = a; m_pd = d;
            end
        end
        #1;
        check("dout_model", dout, m_dout);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_dout = 8'h00; m_pend = 1'b0; m_free = 0;
        reset = 1'b1; transfer = 1'b0; write_en = 1'b0; addr_in = 8'h00; din = 8'h00;

        // reset state, then write A5=3C with transfer held 5 cycles
        tick(1, 0, 0, 8'h00, 8'h00);
        check("reset_dout", dout, 8'h00);
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, 1, 8'hA5, 8'h3C);
            check("dout_during_write", dout, 8'h00);
        end
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 1, 0, 8'hA5, 8'h00);
        tick(0, 1, 0, 8'hA5, 8'h00);
        tick(0, 0, 0, 8'hA5, 8'h00);
        check("read_A5", dout, 8'h3C);
        tick(0, 0, 0, 8'h00, 8'h00);

        // read of an untouched address after reset
        tick(1, 0, 0, 8'h00, 8'h00);
        tick(0, 1, 0, 8'h10, 8'h00);
        tick(0, 0, 0, 8'h10, 8'h00);
        tick(0, 0, 0, 8'h10, 8'h00);
        check("read_10_after_reset", dout, 8'h00);

        // single-cycle pulses write 01=11, 02=22; then back-to-back reads
        tick(0, 1, 1, 8'h01, 8'h11);
        tick(0, 0, 1, 8'h02, 8'h22);
        tick(0, 1, 1, 8'h02, 8'h22);
        tick(0, 0, 1, 8'h03, 8'hEE);
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 1, 0, 8'h01, 8'h00);
        tick(0, 1, 0, 8'h01, 8'h00);
        tick(0, 1, 0, 8'h02, 8'h00);
        check("b2b_read_01", dout, 8'h11);
        tick(0, 1, 0, 8'h02, 8'h00);
        check("b2b_hold", dout, 8'h11);
        tick(0, 0, 0, 8'h00, 8'h00);
        check("b2b_read_02", dout, 8'h22);
        tick(0, 0, 0, 8'h00, 8'h00);
        // pulse wrote only one location: address 03 must still be empty
        tick(0, 1, 0, 8'h03, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        check("pulse_single_xfer", dout, 8'h00);

        // reset during ACCESS of write 33=5A aborts it
        tick(0, 1, 0, 8'h02, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        check("preload_dout", dout, 8'h22);
        tick(0, 1, 1, 8'h33, 8'h5A);
        tick(0, 0, 1, 8'h33, 8'h5A);
        tick(1, 0, 1, 8'h33, 8'h5A);
        tick(0, 1, 0, 8'h33, 8'h00);
        tick(0, 0, 0, 8'h33, 8'h00);
        tick(0, 0, 0, 8'h33, 8'h00);
        check("reset_abort_33", dout, 8'h00);

        // inputs changed during SETUP are ignored
        tick(0, 1, 1, 8'h40, 8'h77);
        tick(0, 0, 1, 8'h41, 8'h99);
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 1, 0, 8'h40, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        check("setup_ignore_40", dout, 8'h77);
        tick(0, 1, 0, 8'h41, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        check("setup_ignore_41", dout, 8'h00);

        // random traffic over a small address window
        for (int k = 0; k < 3000; k++) begin
            tick(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 8'(8'h80 + $urandom_range(0, 7)),
                 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_top.md
APB_TOP -- requirements
Module: apb_top

Interface
REQ-001 The block SHALL have no parameters; all data and address paths are fixed at 8 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge system clock; all state updates on this edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port: transfer  input  1  request to start an APB transfer; level, sampled each rising edge.
REQ-006 Port: write_en  input  1  transfer direction; 1 = write, 0 = read.
REQ-007 Port: din  input  8  write data.
REQ-008 Port: addr_in  input  8  target address.
REQ-009 Port: dout  output  8  registered read data from the last completed read transfer.

Function
REQ-010 The block SHALL contain an APB3 master and one APB3 slave, connected by internal PSEL, PENABLE, PWRITE, PADDR[7:0], PWDATA[7:0], PRDATA[7:0] and PREADY.
REQ-011 The slave SHALL hold a 256 x 8 register-array memory, addressed directly by PADDR.
REQ-012 The master FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-013 In IDLE: PSEL=0 and PENABLE=0; if transfer=1 at a rising edge, the next state is SETUP, else it stays IDLE.
REQ-014 On the IDLE->SETUP edge, and on every ACCESS->SETUP edge, the master SHALL latch addr_in, din and write_en into PADDR, PWDATA and PWRITE.
REQ-015 The master SHALL ignore input changes while in SETUP or ACCESS.
REQ-016 In SETUP: PSEL=1 and PENABLE=0; the next state is always ACCESS, regardless of transfer.
REQ-017 In ACCESS: PSEL=1 and PENABLE=1; the slave drives PREADY=1 (zero wait states), so each transfer completes in this single cycle.
REQ-018 On completion, the next state SHALL be SETUP if transfer=1 (back-to-back transfer), otherwise IDLE.
REQ-019 Write completion: at the ACCESS edge with PWRITE=1, mem[PADDR] <= PWDATA; dout SHALL be unchanged.
REQ-020 Read completion: PRDATA = mem[PADDR] combinationally, and dout <= PRDATA at the ACCESS edge with PWRITE=0.
REQ-021 Latency: with transfer sampled high at edge N in IDLE, the write or the dout update SHALL occur at edge N+2.
REQ-022 Holding transfer high SHALL issue one transfer every 2 cycles, repeating the currently applied inputs.
REQ-023 dout SHALL hold its value at all times other than a read completion.
REQ-024 The slave SHALL write memory only when PSEL & PENABLE & PWRITE & PREADY.

Reset
REQ-025 While reset=1 at a rising edge: the FSM SHALL go to IDLE, and PSEL, PENABLE, PWRITE, PADDR, PWDATA and dout SHALL all be 0.
REQ-026 While reset=1 at a rising edge, all 256 memory locations SHALL be cleared to 8'h00.
REQ-027 Reset asserted mid-transfer (in SETUP or ACCESS) SHALL abort the transfer: no memory write occurs and dout is not updated.
REQ-028 Reset SHALL take priority over transfer at the same edge.

Verification
REQ-029 Reset 1 cycle, then write_en=1, addr_in=A5, din=3C, transfer=1 for 5 cycles, then read addr A5 -> dout=3C within 3 edges of the read request; dout=00 during the write phase.
REQ-030 After reset, read addr 10 -> dout=00.
REQ-031 Write 11 to address 01 and 22 to address 02, then read addresses 01 and 02 back to back with transfer held high -> dout=11, then 22, on consecutive ACCESS edges 2 cycles apart.
REQ-032 transfer pulsed for 1 cycle only -> FSM goes IDLE -> SETUP -> ACCESS -> IDLE, and exactly one transfer occurs.
REQ-033 Assert reset during ACCESS of a write of 5A to address 33, then read address 33 -> dout=00.
REQ-034 Change addr_in and din during SETUP of a write of 77 to address 40 -> mem[40]=77 and the new address is untouched.
